// File: rtl/ex_stage_pkg.sv
// Shared widths, stall encoding, opcode constants and bus layouts for the EX stage.
// Everything the ID/EX/MEM boundary agrees on lives here.
package ex_stage_pkg;

  localparam int StallBus     = 6;
  localparam int ID_TO_EX_WD  = 159;
  localparam int EX_TO_MEM_WD = 141;
  localparam int EX_TO_RF_WD  = 38;

  localparam int STALL_ID = 2;
  localparam int STALL_EX = 3;
  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  localparam logic [5:0] FUNC_DIV  = 6'h1A;
  localparam logic [5:0] FUNC_DIVU = 6'h1B;

  // Bit positions inside the one-hot alu_op field
  localparam int ALU_ADD  = 11;
  localparam int ALU_SUB  = 10;
  localparam int ALU_SLT  = 9;
  localparam int ALU_SLTU = 8;
  localparam int ALU_AND  = 7;
  localparam int ALU_NOR  = 6;
  localparam int ALU_OR   = 5;
  localparam int ALU_XOR  = 4;
  localparam int ALU_SLL  = 3;
  localparam int ALU_SRL  = 2;
  localparam int ALU_SRA  = 1;
  localparam int ALU_LUI  = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [11:0] alu_op;
    logic [2:0]  sel_alu_src1;
    logic [3:0]  sel_alu_src2;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic        sel_rf_res;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
  } id_to_ex_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
    logic        hilo_we;
    logic [31:0] hi;
    logic [31:0] lo;
  } ex_to_mem_t;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} div_state_t;

  function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/ex_stage_div_iter.sv
// Iterative restoring divider: one quotient bit per cycle on magnitudes,
// signs re-applied on the way out. Divide-by-zero forces an all-ones quotient.
module div_iter
  import ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  div_state_t  state_reg;
  logic [5:0]  count_reg;
  logic [31:0] quo_reg;
  logic [31:0] rem_reg;
  logic [31:0] dvsr_reg;
  logic        neg_q_reg;
  logic        neg_r_reg;
  logic        div_zero_reg;

  logic [32:0] trial;
  logic        fits;
  logic [31:0] trial_sub;

  // Partial remainder shifted left with the next dividend bit brought in
  assign trial     = {rem_reg, quo_reg[31]};
  assign fits      = trial >= {1'b0, dvsr_reg};
  assign trial_sub = trial[31:0] - dvsr_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      count_reg    <= 6'd0;
      quo_reg      <= 32'd0;
      rem_reg      <= 32'd0;
      dvsr_reg     <= 32'd0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      div_zero_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            quo_reg      <= abs32(dividend, is_signed);
            dvsr_reg     <= abs32(divisor, is_signed);
            rem_reg      <= 32'd0;
            count_reg    <= 6'd0;
            neg_q_reg    <= is_signed & (dividend[31] ^ divisor[31]);
            neg_r_reg    <= is_signed & dividend[31];
            div_zero_reg <= (divisor == 32'd0);
            state_reg    <= RUN;
          end
        end
        RUN: begin
          rem_reg   <= fits ? trial_sub : trial[31:0];
          quo_reg   <= {quo_reg[30:0], fits};
          count_reg <= count_reg + 6'd1;
          if (count_reg == 6'd31) state_reg <= DONE;
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy      = ((state_reg == IDLE) && start) || (state_reg == RUN);
  assign done      = (state_reg == DONE);
  assign quotient  = div_zero_reg ? 32'hFFFF_FFFF : (neg_q_reg ? (32'd0 - quo_reg) : quo_reg);
  assign remainder = neg_r_reg ? (32'd0 - rem_reg) : rem_reg;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ID/EX pipeline register, one-hot ALU, data SRAM request
// and an iterative DIV/DIVU unit that stalls the pipe while it runs.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [StallBus-1:0]     stall,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic [EX_TO_RF_WD-1:0]  ex_to_rf_bus,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_wen,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata,
  output logic                    stallreq_for_ex
);

  id_to_ex_t   ex_reg;
  logic        div_served_reg;

  logic [31:0] imm_sext;
  logic [31:0] imm_zext;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [31:0] alu_result;
  logic        is_div;
  logic        div_signed;
  logic        div_start;
  logic        div_busy;
  logic        div_done;
  logic [31:0] div_quo;
  logic [31:0] div_rem;
  ex_to_mem_t  mem_out;
  logic        unused_bits;

  // div_served blocks a restart while a finished divide is held in EX
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_reg         <= '0;
      div_served_reg <= 1'b0;
    end else if (stall[STALL_ID] == Stop && stall[STALL_EX] == NoStop) begin
      ex_reg         <= '0;
      div_served_reg <= 1'b0;
    end else if (stall[STALL_ID] == NoStop) begin
      ex_reg         <= id_to_ex_t'(id_to_ex_bus);
      div_served_reg <= 1'b0;
    end else if (div_done) begin
      div_served_reg <= 1'b1;
    end
  end

  assign imm_sext = {{16{ex_reg.inst[15]}}, ex_reg.inst[15:0]};
  assign imm_zext = {16'd0, ex_reg.inst[15:0]};

  always_comb begin
    src1 = ({32{ex_reg.sel_alu_src1[0]}} & ex_reg.rdata1)
         | ({32{ex_reg.sel_alu_src1[1]}} & ex_reg.pc)
         | ({32{ex_reg.sel_alu_src1[2]}} & {27'd0, ex_reg.inst[10:6]});
    src2 = ({32{ex_reg.sel_alu_src2[0]}} & ex_reg.rdata2)
         | ({32{ex_reg.sel_alu_src2[1]}} & imm_sext)
         | ({32{ex_reg.sel_alu_src2[2]}} & 32'd8)
         | ({32{ex_reg.sel_alu_src2[3]}} & imm_zext);
  end

  always_comb begin
    alu_result = 32'd0;
    if (ex_reg.alu_op[ALU_ADD])  alu_result = alu_result | (src1 + src2);
    if (ex_reg.alu_op[ALU_SUB])  alu_result = alu_result | (src1 - src2);
    if (ex_reg.alu_op[ALU_SLT])  alu_result = alu_result | {31'd0, $signed(src1) < $signed(src2)};
    if (ex_reg.alu_op[ALU_SLTU]) alu_result = alu_result | {31'd0, src1 < src2};
    if (ex_reg.alu_op[ALU_AND])  alu_result = alu_result | (src1 & src2);
    if (ex_reg.alu_op[ALU_NOR])  alu_result = alu_result | ~(src1 | src2);
    if (ex_reg.alu_op[ALU_OR])   alu_result = alu_result | (src1 | src2);
    if (ex_reg.alu_op[ALU_XOR])  alu_result = alu_result | (src1 ^ src2);
    if (ex_reg.alu_op[ALU_SLL])  alu_result = alu_result | (src2 << src1[4:0]);
    if (ex_reg.alu_op[ALU_SRL])  alu_result = alu_result | (src2 >> src1[4:0]);
    if (ex_reg.alu_op[ALU_SRA])  alu_result = alu_result | 32'($signed(src2) >>> src1[4:0]);
    if (ex_reg.alu_op[ALU_LUI])  alu_result = alu_result | {src2[15:0], 16'd0};
  end

  assign div_signed = (ex_reg.inst[5:0] == FUNC_DIV);
  assign is_div     = (ex_reg.inst[31:26] == 6'd0) && (div_signed || ex_reg.inst[5:0] == FUNC_DIVU);
  assign div_start  = is_div && !div_served_reg;

  div_iter u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .is_signed (div_signed),
    .dividend  (ex_reg.rdata1),
    .divisor   (ex_reg.rdata2),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  assign stallreq_for_ex = div_busy;

  always_comb begin
    mem_out              = '0;
    mem_out.pc           = ex_reg.pc;
    mem_out.data_ram_en  = ex_reg.data_ram_en;
    mem_out.data_ram_wen = ex_reg.data_ram_wen;
    mem_out.sel_rf_res   = ex_reg.sel_rf_res;
    mem_out.rf_we        = ex_reg.rf_we;
    mem_out.rf_waddr     = ex_reg.rf_waddr;
    mem_out.ex_result    = alu_result;
    mem_out.hilo_we      = div_done;
    mem_out.hi           = div_done ? div_rem : 32'd0;
    mem_out.lo           = div_done ? div_quo : 32'd0;
  end

  assign ex_to_mem_bus   = mem_out;
  assign ex_to_rf_bus    = {ex_reg.rf_we, ex_reg.rf_waddr, alu_result};
  assign data_sram_en    = ex_reg.data_ram_en;
  assign data_sram_wen   = ex_reg.data_ram_wen;
  assign data_sram_addr  = alu_result;
  assign data_sram_wdata = ex_reg.rdata2;

  // Stall lanes for other stages and the rs/rt/rd fields are not consumed here
  assign unused_bits = ^{stall[StallBus-1:STALL_EX+1], stall[STALL_ID-1:0], ex_reg.inst[25:11]};

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The module SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-003 The module SHALL have port stall, input, StallBus bits: pipeline stall vector; bit 2 is the ID stall and bit 3 is the EX stall.
REQ-004 The module SHALL have port id_to_ex_bus, input, ID_TO_EX_WD (159) bits, with fields {pc 158:127, inst 126:95, alu_op 94:83, sel_alu_src1 82:80, sel_alu_src2 79:76, data_ram_en 75, data_ram_wen 74:71, rf_we 70, rf_waddr 69:65, sel_rf_res 64, rdata1 63:32, rdata2 31:0}.
REQ-005 The module SHALL have port ex_to_mem_bus, output, EX_TO_MEM_WD bits, with fields {pc, data_ram_en, data_ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result, hilo_we, hi, lo}.
REQ-006 The module SHALL have port ex_to_rf_bus, output, EX_TO_RF_WD (38) bits, with fields {rf_we, rf_waddr, ex_result}, for ID forwarding.
REQ-007 The module SHALL have data_sram ports: data_sram_en out 1, data_sram_wen out 4, data_sram_addr out 32, data_sram_wdata out 32.
REQ-008 The module SHALL have port stallreq_for_ex, output, 1 bit: requests a pipeline stall while a divide is in progress.

Function
REQ-009 The pipeline register SHALL load as follows: bubble (all-zero) when stall[2]=Stop and stall[3]=NoStop; load id_to_ex_bus when stall[2]=NoStop; otherwise hold.
REQ-010 src1 SHALL be selected one-hot: rdata1, pc, or zero-extended inst[10:6]; src2 SHALL be selected one-hot: rdata2, sign-extended imm, 32'd8, or zero-extended imm; when no select bit is set, the operand SHALL be 0.
REQ-011 The ALU SHALL be one-hot on alu_op {add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui}: add/sub are modulo 2^32 with no trap; shifts use src1[4:0] as the shift amount on src2; lui gives {src2[15:0], 16'b0}; all-zero alu_op gives result 0; the ALU is combinational with the result in the same cycle.
REQ-012 The data SRAM request SHALL be issued in the same cycle: en = data_ram_en; wen = data_ram_wen; addr = ALU result; wdata = rdata2.
REQ-013 DIV is opcode 0 with func 6'h1A and DIVU is opcode 0 with func 6'h1B; both SHALL be decoded from the registered inst.
REQ-014 The divider FSM SHALL have states IDLE, RUN, and DONE.
REQ-015 In IDLE, when a divide is present and div_served=0, the FSM SHALL assert stallreq_for_ex, latch |rs| and |rt| (raw values for DIVU) plus the result signs, and go to RUN.
REQ-016 RUN SHALL perform restoring shift-subtract, one quotient bit per cycle, for exactly 32 cycles, using a 6-bit counter; stallreq_for_ex SHALL stay 1; then the FSM goes to DONE.
REQ-017 In DONE, stallreq_for_ex SHALL be 0, hilo_we SHALL be 1, lo SHALL be the quotient, and hi SHALL be the remainder; the FSM SHALL set div_served and return to IDLE.
REQ-018 Total divide stall SHALL be 33 cycles, and the result SHALL appear in the 34th cycle of EX residency.
REQ-019 Signed divide SHALL negate the quotient if the operand signs differ and give the remainder the sign of the dividend; 0x80000000 / -1 SHALL give lo=0x80000000 and hi=0.
REQ-020 Divide by zero SHALL give lo=0xFFFFFFFF and hi=the dividend, after the full 33-cycle stall.
REQ-021 div_served SHALL clear whenever the pipeline register loads, so that a divide held in EX by an external stall after DONE does not restart.
REQ-022 hilo_we SHALL be 0 on every non-divide cycle; ex_to_rf_bus.rf_we SHALL follow the registered rf_we unchanged.

Reset
REQ-023 On rst=0 (asynchronous), the pipeline register, FSM (IDLE), counter, div_served, and dividend/divisor registers SHALL all clear to zero.
REQ-024 As a consequence of reset, all outputs SHALL be 0, including data_sram_en, stallreq_for_ex, and hilo_we.
REQ-025 Reset asserted during RUN SHALL abort the divide with no hilo_we pulse.

Structure
REQ-026 ID_TO_EX_WD, EX_TO_MEM_WD, EX_TO_RF_WD, StallBus, Stop/NoStop, and the DIV/DIVU func codes SHALL live in the shared defines package.
REQ-027 The divider SHALL be one sub-module, div_iter (start, signed, operands in; busy, done, quotient, remainder out); the ALU SHALL be inline.

Verification
REQ-028 The bench SHALL cover: addiu with rdata1=0x7FFFFFFF and imm=1 -> ex_result=0x80000000 in the same cycle, rf_we=1.
REQ-029 The bench SHALL cover: DIV with rs=-7 and rt=2 -> stallreq=1 for 33 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF, hilo_we=1 for 1 cycle.
REQ-030 The bench SHALL cover: DIVU with rs=0x10 and rt=0 -> 33-cycle stall, lo=0xFFFFFFFF, hi=0x10.
REQ-031 The bench SHALL cover: DIV held by an external stall[3]=Stop for 5 cycles after DONE -> no restart and a single hilo_we pulse.
REQ-032 The bench SHALL cover: rst=0 at RUN cycle 10 -> stallreq and all outputs 0 immediately, FSM=IDLE.
REQ-033 The bench SHALL cover: stall[2]=Stop with stall[3]=NoStop -> the next cycle is a bubble with data_sram_en=0 and rf_we=0.
